// File: rtl/gate_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : gate_share_arb
// Purpose  : Round-robin arbiter that time-shares one combinational gate
//            datapath between three requesters. A winner's operands are
//            registered onto A/B/C for one DRIVE cycle. The datapath results
//            X/Y/Z are captured on the following edge and returned to the
//            owner with a one-cycle rsp_valid pulse.
// Ports    : clk, rst (async, active-high)
//            req[2:0], req_A/B/C[3*W-1:0]  requester levels and packed operands
//            gnt[2:0]                      one-hot grant pulse
//            A/B/C[W-1:0]                  operands to the shared datapath
//            X/Y/Z[W-1:0]                  datapath results (combinational)
//            rsp_valid[2:0], rsp_X/Y/Z     one-hot response pulse and results
//            busy                          high whenever not IDLE
// Revision : 1.0  initial release
// ============================================================================
module gate_share_arb #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     req,
    input  logic [3*W-1:0] req_A,
    input  logic [3*W-1:0] req_B,
    input  logic [3*W-1:0] req_C,
    output logic [2:0]     gnt,
    output logic [W-1:0]   A,
    output logic [W-1:0]   B,
    output logic [W-1:0]   C,
    input  logic [W-1:0]   X,
    input  logic [W-1:0]   Y,
    input  logic [W-1:0]   Z,
    output logic [2:0]     rsp_valid,
    output logic [W-1:0]   rsp_X,
    output logic [W-1:0]   rsp_Y,
    output logic [W-1:0]   rsp_Z,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_last;     // index of the most recently completed grant
    logic [1:0] r_owner;    // index of the transaction in flight
    logic [1:0] w_ord0;     // round-robin search order, highest priority first
    logic [1:0] w_ord1;
    logic [1:0] w_ord2;
    logic [1:0] w_pick;
    logic       w_any;

    // Search order begins just after the last completed grant. Reset leaves
    // r_last at 2, so requester 0 is favoured first.
    always_comb begin
        w_ord0 = 2'd0;
        w_ord1 = 2'd1;
        w_ord2 = 2'd2;
        case (r_last)
            2'd0: begin
                w_ord0 = 2'd1;
                w_ord1 = 2'd2;
                w_ord2 = 2'd0;
            end
            2'd1: begin
                w_ord0 = 2'd2;
                w_ord1 = 2'd0;
                w_ord2 = 2'd1;
            end
            default: begin
                w_ord0 = 2'd0;
                w_ord1 = 2'd1;
                w_ord2 = 2'd2;
            end
        endcase
    end

    // Priority pick. w_pick is only used when w_any is set, so the fallback
    // to w_ord2 is harmless when nothing is requesting.
    always_comb begin
        w_any  = |req;
        w_pick = w_ord2;
        if (req[w_ord1]) begin
            w_pick = w_ord1;
        end
        if (req[w_ord0]) begin
            w_pick = w_ord0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_any) w_state_nxt = S_DRIVE;
            S_DRIVE:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // gnt and rsp_valid default low every cycle so that they are single-cycle
    // pulses. A reset mid-transaction clears r_state before CAPTURE is
    // reached, which is what suppresses the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last    <= 2'd2;
            r_owner   <= 2'd0;
            gnt       <= 3'b000;
            rsp_valid <= 3'b000;
            A         <= '0;
            B         <= '0;
            C         <= '0;
            rsp_X     <= '0;
            rsp_Y     <= '0;
            rsp_Z     <= '0;
        end else begin
            gnt       <= 3'b000;
            rsp_valid <= 3'b000;
            if (r_state == S_IDLE && w_any) begin
                gnt     <= 3'b001 << w_pick;
                r_owner <= w_pick;
                A       <= req_A[w_pick*W +: W];
                B       <= req_B[w_pick*W +: W];
                C       <= req_C[w_pick*W +: W];
            end
            if (r_state == S_CAPTURE) begin
                rsp_X     <= X;
                rsp_Y     <= Y;
                rsp_Z     <= Z;
                rsp_valid <= 3'b001 << r_owner;
                r_last    <= r_owner;
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gate_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_share_arb
// Purpose  : Self-checking bench for gate_share_arb with a gate datapath
//            model X=A&B, Y=A|C, Z=B^C at W=4. Expected responses are queued
//            when requests are driven and popped when rsp_valid pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_gate_share_arb;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [2:0]     req;
    logic [3*W-1:0] req_A;
    logic [3*W-1:0] req_B;
    logic [3*W-1:0] req_C;
    logic [2:0]     gnt;
    logic [W-1:0]   A, B, C;
    logic [W-1:0]   X, Y, Z;
    logic [2:0]     rsp_valid;
    logic [W-1:0]   rsp_X, rsp_Y, rsp_Z;
    logic           busy;

    gate_share_arb #(.W(W)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_A(req_A), .req_B(req_B), .req_C(req_C),
        .gnt(gnt), .A(A), .B(B), .C(C),
        .X(X), .Y(Y), .Z(Z),
        .rsp_valid(rsp_valid), .rsp_X(rsp_X), .rsp_Y(rsp_Y), .rsp_Z(rsp_Z),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared gate datapath model.
    assign X = A & B;
    assign Y = A | C;
    assign Z = B ^ C;

    typedef struct packed {
        logic [2:0] v;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    logic [3:0] oa[3];
    logic [3:0] ob[3];
    logic [3:0] oc[3];

    function automatic exp_t mk(input int i, input logic [3:0] a, b, c);
        exp_t e;
        e.v = 3'b001 << i;
        e.x = a & b;
        e.y = a | c;
        e.z = b ^ c;
        return e;
    endfunction

    task automatic set_ops(input int i, input logic [3:0] a, b, c);
        oa[i] = a;
        ob[i] = b;
        oc[i] = c;
        req_A[i*W +: W] = a;
        req_B[i*W +: W] = b;
        req_C[i*W +: W] = c;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 3'b000; req_A = '0; req_B = '0; req_C = '0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({A, B, C} !== 12'h000) begin errors++; $display("FAIL reset_abc: got %h want 000", {A, B, C}); end
        checks++; if ({rsp_X, rsp_Y, rsp_Z} !== 12'h000) begin errors++; $display("FAIL reset_rsp: got %h want 000", {rsp_X, rsp_Y, rsp_Z}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        exp_t e;
        set_ops(0, 4'b1111, 4'b1010, 4'b0000);
        sbq.push_back({3'b001, 4'b1010, 4'b1111, 4'b1010});
        req = 3'b001;
        @(negedge clk);
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b want 001", gnt); end
        checks++; if ({A, B, C} !== 12'b1111_1010_0000) begin errors++; $display("FAIL single_abc: got %b want 111110100000", {A, B, C}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        req = 3'b000;
        @(negedge clk);
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL single_gnt_drop: got %b want 000", gnt); end
        checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL single_early_rsp: got %b want 000", rsp_valid); end
        @(negedge clk);
        checks++;
        if (sbq.size() == 0) begin
            errors++; $display("FAIL single_sb_empty: got 0 entries want 1");
        end else begin
            e = sbq.pop_front();
            checks++; if (rsp_valid !== e.v) begin errors++; $display("FAIL single_rsp_valid: got %b want %b", rsp_valid, e.v); end
            checks++; if ({rsp_X, rsp_Y, rsp_Z} !== {e.x, e.y, e.z}) begin errors++; $display("FAIL single_rsp_data: got %b want %b", {rsp_X, rsp_Y, rsp_Z}, {e.x, e.y, e.z}); end
        end
        @(negedge clk);
        checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL single_rsp_pulse: got %b want 000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
        checks++; if ({rsp_X, rsp_Y, rsp_Z} !== 12'b1010_1111_1010) begin errors++; $display("FAIL single_rsp_hold: got %b want 101011111010", {rsp_X, rsp_Y, rsp_Z}); end
        checks++; if ({A, B, C} !== 12'b1111_1010_0000) begin errors++; $display("FAIL single_abc_hold: got %b want 111110100000", {A, B, C}); end
    endtask

    // Runs requests with the given mask until n grants are seen, checking
    // grant order, spacing, operands and every response against the queue.
    task automatic test_contention_core(input string tag, input logic [2:0] mask,
                                        input int n, input int o0, o1, o2, o3);
        int   order[4];
        int   ng, nr, last_g;
        exp_t e;
        order[0] = o0; order[1] = o1; order[2] = o2; order[3] = o3;
        for (int k = 0; k < n; k++) sbq.push_back(mk(order[k], oa[order[k]], ob[order[k]], oc[order[k]]));
        ng = 0; nr = 0; last_g = 0;
        req = mask;
        for (int cyc = 0; cyc < 40 && nr < n; cyc++) begin
            @(negedge clk);
            if (gnt !== 3'b000) begin
                checks++;
                if (ng >= n) begin
                    errors++; $display("FAIL %s_extra_gnt: got %b want 000", tag, gnt);
                end else begin
                    if (gnt !== (3'b001 << order[ng])) begin errors++; $display("FAIL %s_gnt%0d: got %b want %b", tag, ng, gnt, 3'b001 << order[ng]); end
                    checks++;
                    if ({A, B, C} !== {oa[order[ng]], ob[order[ng]], oc[order[ng]]}) begin
                        errors++; $display("FAIL %s_abc%0d: got %b want %b", tag, ng, {A, B, C}, {oa[order[ng]], ob[order[ng]], oc[order[ng]]});
                    end
                    if (ng > 0) begin
                        checks++; if (cyc - last_g != 3) begin errors++; $display("FAIL %s_spacing%0d: got %0d want 3", tag, ng, cyc - last_g); end
                    end
                end
                last_g = cyc;
                ng++;
                if (ng == n) req = 3'b000;
            end
            if (rsp_valid !== 3'b000) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL %s_unexpected_rsp: got %b want 000", tag, rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (rsp_valid !== e.v) begin errors++; $display("FAIL %s_rsp_valid%0d: got %b want %b", tag, nr, rsp_valid, e.v); end
                    checks++;
                    if ({rsp_X, rsp_Y, rsp_Z} !== {e.x, e.y, e.z}) begin
                        errors++; $display("FAIL %s_rsp_data%0d: got %b want %b", tag, nr, {rsp_X, rsp_Y, rsp_Z}, {e.x, e.y, e.z});
                    end
                end
                checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL %s_gnt_with_rsp: got %b want 000", tag, gnt); end
                nr++;
            end
        end
        req = 3'b000;
        checks++; if (nr != n) begin errors++; $display("FAIL %s_timeout: got %0d responses want %0d", tag, nr, n); end
        while (sbq.size() > 0) void'(sbq.pop_front());
        @(negedge clk);
    endtask

    task automatic test_contention;
        pulse_reset();
        set_ops(0, 4'b0011, 4'b0101, 4'b1001);
        set_ops(1, 4'b1100, 4'b0110, 4'b0010);
        set_ops(2, 4'b0111, 4'b1110, 4'b1000);
        test_contention_core("contention", 3'b111, 4, 0, 1, 2, 0);
    endtask

    task automatic test_round_robin;
        pulse_reset();
        set_ops(1, 4'b1001, 4'b0011, 4'b0100);
        set_ops(2, 4'b0110, 4'b1111, 4'b0001);
        test_contention_core("rr", 3'b110, 2, 1, 2, 0, 0);
    endtask

    task automatic test_drop;
        exp_t e;
        int   nr;
        logic saw_g1;
        set_ops(0, 4'b0101, 4'b1100, 4'b0011);
        set_ops(1, 4'b1110, 4'b0111, 4'b1011);
        sbq.push_back(mk(0, oa[0], ob[0], oc[0]));
        req = 3'b001;
        @(negedge clk);
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL drop_gnt0: got %b want 001", gnt); end
        req = 3'b010;
        @(negedge clk);
        req = 3'b000;
        nr = 0; saw_g1 = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (gnt[1] === 1'b1) saw_g1 = 1'b1;
            if (rsp_valid !== 3'b000) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL drop_unexpected_rsp: got %b want 000", rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (rsp_valid !== e.v) begin errors++; $display("FAIL drop_rsp_valid: got %b want %b", rsp_valid, e.v); end
                    checks++;
                    if ({rsp_X, rsp_Y, rsp_Z} !== {e.x, e.y, e.z}) begin errors++; $display("FAIL drop_rsp_data: got %b want %b", {rsp_X, rsp_Y, rsp_Z}, {e.x, e.y, e.z}); end
                end
                nr++;
            end
        end
        checks++; if (saw_g1 !== 1'b0) begin errors++; $display("FAIL drop_gnt1: got 1 want 0"); end
        checks++; if (nr != 1) begin errors++; $display("FAIL drop_rsp_count: got %0d want 1", nr); end
    endtask

    task automatic test_abort;
        exp_t e;
        set_ops(0, 4'b1011, 4'b1000, 4'b0001);
        req = 3'b001;
        @(negedge clk);
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL abort_gnt: got %b want 001", gnt); end
        checks++; if ({A, B, C} !== 12'b1011_1000_0001) begin errors++; $display("FAIL abort_abc: got %b want 101110000001", {A, B, C}); end
        req = 3'b000;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({gnt, rsp_valid, busy} !== 7'b0) begin errors++; $display("FAIL abort_ctrl: got %b want 0000000", {gnt, rsp_valid, busy}); end
        checks++; if ({A, B, C, rsp_X, rsp_Y, rsp_Z} !== 24'h0) begin errors++; $display("FAIL abort_data: got %h want 000000", {A, B, C, rsp_X, rsp_Y, rsp_Z}); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL abort_rsp%0d: got %b want 000", k, rsp_valid); end
        end
        rst = 1'b0;
        sbq.push_back({3'b001, 4'b1000, 4'b1011, 4'b1001});
        req = 3'b001;
        @(negedge clk);
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL abort_regnt: got %b want 001", gnt); end
        req = 3'b000;
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() == 0) begin
            errors++; $display("FAIL abort_sb_empty: got 0 entries want 1");
        end else begin
            e = sbq.pop_front();
            if (rsp_valid !== e.v) begin errors++; $display("FAIL abort_rsp_valid: got %b want %b", rsp_valid, e.v); end
            checks++;
            if ({rsp_X, rsp_Y, rsp_Z} !== {e.x, e.y, e.z}) begin errors++; $display("FAIL abort_rsp_data: got %b want %b", {rsp_X, rsp_Y, rsp_Z}, {e.x, e.y, e.z}); end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b000;
        req_A = '0; req_B = '0; req_C = '0;
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_drop();
        test_abort();
        checks++; if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sbq.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
